// File: rtl/audio_pkg.sv
// Shared audio-chain types and frame geometry.
package audio_pkg;
   localparam int SAMPLE_W    = 16;
   localparam int SLOT_W      = 32;
   localparam int FRAME_SLOTS = 64;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO with extra-MSB pointers; a pop in the same cycle frees room for a push.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  sample_t                      din,
   output sample_t                      dout,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [AW:0] wptr, rptr;
   sample_t     mem [DEPTH];
   logic        do_push, do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];
   assign level   = LW'(wptr - rptr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: mono sample sent on both channels of a 64-slot Philips frame.
// Optional: define I2S_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of silence.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int BCLK_HALF  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [15:0]                       sample_in,
   input  logic                              sample_in_valid,
   output logic                              i2s_bclk,
   output logic                              i2s_lrclk,
   output logic                              i2s_sdata,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              underrun,
   output logic                              overflow
);
   localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int SW = $clog2(FRAME_SLOTS);
   localparam int MW = $clog2(SLOT_W);
   localparam int BW = $clog2(SAMPLE_W);

   logic [DW-1:0] div_cnt;
   logic [SW-1:0] slot, slot_nxt;
   logic [MW-1:0] m;
   logic [BW-1:0] idx;
   sample_t       shift, head;
   logic          tc, fall_tick, pop_tick, bit_on, sdata_nxt;
   logic          full, empty;

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (sample_in_valid),
      .pop   (pop_tick),
      .din   (sample_in),
      .dout  (head),
      .level (fifo_level),
      .full  (full),
      .empty (empty)
   );

   assign tc        = (div_cnt == DW'(BCLK_HALF - 1));
   assign fall_tick = tc && i2s_bclk;
   assign slot_nxt  = slot + 1'b1;
   assign pop_tick  = fall_tick && (slot_nxt == '0);

   // Position within the half-frame; slot 0 of each half is the one-BCLK I2S delay.
   assign m         = slot_nxt[MW-1:0];
   assign bit_on    = (m != '0) && (m <= MW'(SAMPLE_W));
   assign idx       = BW'(SAMPLE_W - int'(m));
   assign sdata_nxt = bit_on ? shift[idx] : 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         slot      <= '1;
         i2s_lrclk <= 1'b1;
         i2s_sdata <= 1'b0;
      end else begin
         div_cnt <= tc ? '0 : div_cnt + 1'b1;
         if (tc) i2s_bclk <= ~i2s_bclk;
         if (fall_tick) begin
            slot      <= slot_nxt;
            i2s_lrclk <= slot_nxt[SW-1];
            i2s_sdata <= sdata_nxt;
         end
      end
   end

`ifdef I2S_UNDERRUN_HOLD_EN
   sample_t hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift <= '0;
         hold  <= '0;
      end else if (pop_tick) begin
         if (!empty) begin
            shift <= head;
            hold  <= head;
         end else begin
            shift <= hold;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          shift <= '0;
      else if (pop_tick) shift <= empty ? '0 : head;
   end
`endif

   // A pop in the same cycle makes room, so a push into a full FIFO is only dropped without one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         underrun <= pop_tick && empty;
         overflow <= sample_in_valid && full && !pop_tick;
      end
   end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Final output stage of the audio chain. Consumes the 48 kHz mono stream produced by the oversampled distortion path (decimated 16-bit samples with a one-cycle valid strobe).
- Buffers the samples in a small FIFO and serialises each one as a standard Philips I2S stereo frame to the external DAC. The same sample is sent on left and right.
- Generates BCLK and LRCLK locally from clk. The block is I2S master.

Parameters:
- BCLK_HALF, 16: clk cycles per BCLK half-period. 98.304 MHz / 32 = 3.072 MHz = 64 × 48 kHz.
- FIFO_DEPTH, 4: sample buffer entries. Power of two, ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- sample_in  input  16  signed two's-complement sample
- sample_in_valid  input  1  one-cycle strobe, sample_in qualified
- i2s_bclk  output  1  bit clock
- i2s_lrclk  output  1  word select: 0 = left, 1 = right
- i2s_sdata  output  1  serial data, MSB first
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current occupancy
- underrun  output  1  one-cycle pulse: frame start found the FIFO empty
- overflow  output  1  one-cycle pulse: push dropped because the FIFO was full

Behaviour:
- Reset values (rst low, async):
  - bclk=0, lrclk=1, sdata=0.
  - div_cnt=0, slot=63.
  - FIFO empty; level=0; flags=0.
  - shift register and hold register = 0.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1.
  - At terminal count, bclk toggles and div_cnt wraps to 0.
  - First rising edge occurs BCLK_HALF cycles after reset release; first falling edge at 2×BCLK_HALF.
- Slot counter:
  - slot (6 bits) increments on each bclk 1→0 toggle, wrapping 63→0.
  - lrclk, sdata and slot all register on the same clk edge as the falling toggle. The DAC samples on bclk rising.
- Frame format, slot b, with m = b mod 32:
  - lrclk = b[5].
  - sdata = shift[15-(m-1)] for m in 1..16; 0 for m = 0 and m in 17..31. This gives the one-BCLK I2S delay and zero padding.
  - The same 16-bit word is sent for left (b = 1..16) and right (b = 33..48).
- Pop: on the falling edge that enters slot 0:
  - FIFO not empty: pop head into shift; level decrements.
  - FIFO empty: load the underrun value (see Optional Feature) and pulse underrun for exactly 1 clk.
- Push: on sample_in_valid:
  - Not full: write at the tail.
  - Full: drop the sample and pulse overflow for 1 clk.
- Simultaneous push and pop in the same cycle:
  - FIFO full: the pop frees an entry, so the push is accepted. Level unchanged, no overflow.
  - FIFO empty: the pop underruns, the push is stored, level ends at 1.
- Latency: a sample pushed into an empty FIFO appears at the next slot-0 boundary. Its MSB is on sdata one BCLK later (slot 1). Worst case ≈ 1 frame + 2×BCLK_HALF clk.
- Pointer wrap: read/write pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB comparison.
- Reset asserted mid-frame: all outputs return to reset values immediately. Buffered samples are discarded. The frame restarts cleanly after release.
- Input rate: upstream averages 1 sample per 2048 clk, matching the consumption rate. The FIFO absorbs jitter only; no backpressure exists.

Optional Feature:
- Macro: I2S_UNDERRUN_HOLD_EN.
- Defined: on underrun, shift reloads from the hold register, i.e. the last successfully popped sample is repeated. Hold updates on every successful pop.
- Undefined: shift loads 16'h0000 on underrun (silence). No hold register is built.
- underrun pulses in both builds.

Decomposition:
- audio_pkg carries:
  - SAMPLE_W = 16, SLOT_W = 32, FRAME_SLOTS = 64;
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
- One sub-module: sample_fifo.
  - Parameter: DEPTH.
  - Interface: push/pop/din/dout/level/full/empty.
  - Reused elsewhere in the chain.
- i2s_tx holds the divider, slot counter, shift and hold registers, and flags.

Test Plan:
- Reset release, no input, 2 frames:
  - bclk period = 32 clk; lrclk toggles every 32 bclk (low for slots 0–31, high for 32–63).
  - sdata constant 0; underrun pulses once per frame (2 pulses).
- Push 16'hA5C3 once before the first slot 0:
  - decoded left word = A5C3, MSB in slot 1, slots 17–31 zero; right word = A5C3 in slots 33–48;
  - no underrun that frame; level 1→0 at slot 0.
- Push 6 samples 16'h0001..16'h0006 back-to-back with FIFO_DEPTH=4:
  - overflow pulses on pushes 5 and 6;
  - frames carry 0001, 0002, 0003, 0004 in order, then underrun.
- Push 16'h8000 then stop:
  - I2S_UNDERRUN_HOLD_EN defined: next frame repeats 8000, underrun pulses.
  - I2S_UNDERRUN_HOLD_EN undefined: next frame is 0000, underrun pulses.
- FIFO full (level 4), sample_in_valid asserted on the slot-0 pop cycle:
  - no overflow, level stays 4, the new sample is last in order.
- Assert rst low at slot 20 with level 3:
  - all outputs at reset values within the same cycle, level=0;
  - after release, the first falling bclk comes at 2×BCLK_HALF and enters slot 0.
